// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: instruction field positions and widths,
// the default bubble word, and a helper that splits a word into its fields.
package mips_pipe_pkg;

    localparam int MIPS_INSTR_W = 32;

    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = 6;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int REG_W      = 5;
    localparam int FUNC_LSB   = 0;
    localparam int FUNC_W     = 6;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = 16;
    localparam int JADDR_LSB  = 0;
    localparam int JADDR_W    = 26;

    localparam logic [MIPS_INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    shamt;
        logic [FUNC_W-1:0]   func;
        logic [IMM_W-1:0]    imm;
        logic [JADDR_W-1:0]  jaddr;
    } mips_fields_t;

    function automatic mips_fields_t mips_decode(input logic [MIPS_INSTR_W-1:0] w);
        mips_fields_t f;
        f.opcode = w[OPCODE_LSB +: OPCODE_W];
        f.rs     = w[RS_LSB     +: REG_W];
        f.rt     = w[RT_LSB     +: REG_W];
        f.rd     = w[RD_LSB     +: REG_W];
        f.shamt  = w[SHAMT_LSB  +: REG_W];
        f.func   = w[FUNC_LSB   +: FUNC_W];
        f.imm    = w[IMM_LSB    +: IMM_W];
        f.jaddr  = w[JADDR_LSB  +: JADDR_W];
        return f;
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// IF->ID boundary bundle: upstream offer/accept, downstream hold/consume,
// decoded fields and the back-pressure counter.
interface if_id_stage_if #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  PCplus4;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] IF_ID_Instr;
    logic [5:0]         IF_ID_Opcode;
    logic [4:0]         IF_ID_Rs;
    logic [4:0]         IF_ID_Rt;
    logic [4:0]         IF_ID_Rd;
    logic [4:0]         IF_ID_Shamt;
    logic [5:0]         IF_ID_Func;
    logic [15:0]        IF_ID_Immediate;
    logic [25:0]        IF_ID_Address;
    logic [ADDR_W-1:0]  IF_ID_PCplus4;
    logic [CNT_W-1:0]   stall_cnt;

    // The stage itself.
    modport slave (
        input  in_valid, instruction, PCplus4, out_ready,
        output in_ready, out_valid, IF_ID_Instr, IF_ID_Opcode, IF_ID_Rs, IF_ID_Rt,
               IF_ID_Rd, IF_ID_Shamt, IF_ID_Func, IF_ID_Immediate, IF_ID_Address,
               IF_ID_PCplus4, stall_cnt
    );

    // The surrounding pipeline (fetch on one side, decode on the other).
    modport master (
        output in_valid, instruction, PCplus4, out_ready,
        input  in_ready, out_valid, IF_ID_Instr, IF_ID_Opcode, IF_ID_Rs, IF_ID_Rt,
               IF_ID_Rd, IF_ID_Shamt, IF_ID_Func, IF_ID_Immediate, IF_ID_Address,
               IF_ID_PCplus4, stall_cnt
    );
endinterface

// File: rtl/if_id_skid_buf.sv
// Two-entry FIFO skid buffer between fetch and decode; main drives the
// outputs, skid absorbs the one word that arrives while main is stalled.
module if_id_skid_buf #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               skid_valid
);
    // A word moves on a side only in a cycle where that side's valid and
    // ready are both high; valid never waits on ready. in_ready is purely
    // the registered skid-empty flag, so out_ready never reaches it.
    logic               main_valid;
    logic [INSTR_W-1:0] main_instr;
    logic [ADDR_W-1:0]  main_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic               accept;
    logic               drain;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_instr = main_instr;
    assign out_pc    = main_pc;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_instr <= '0;
            main_pc    <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                // Skid full implies in_ready=0, so nothing can arrive here.
                main_instr <= skid_instr;
                main_pc    <= skid_pc;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_instr <= in_instr;
                main_pc    <= in_pc;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_instr <= in_instr;
                skid_pc    <= in_pc;
                skid_valid <= 1'b1;
            end else begin
                main_instr <= in_instr;
                main_pc    <= in_pc;
                main_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: skid-buffered handshake, MIPS field decode of the
// held word (bubble word when empty), and a saturating back-pressure counter.
module if_id_stage
    import mips_pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 ADDR_W    = 32,
    parameter int                 CNT_W     = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    input logic           flush,
    if_id_stage_if.slave  bus
);
    logic               main_valid;
    logic               skid_valid;
    logic [INSTR_W-1:0] main_instr;
    logic [ADDR_W-1:0]  main_pc;
    logic [INSTR_W-1:0] held_instr;
    mips_fields_t       fields;
    logic [CNT_W-1:0]   stall_q;

    if_id_skid_buf #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_skid_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (bus.in_valid),
        .in_ready   (bus.in_ready),
        .in_instr   (bus.instruction),
        .in_pc      (bus.PCplus4),
        .out_valid  (main_valid),
        .out_ready  (bus.out_ready),
        .out_instr  (main_instr),
        .out_pc     (main_pc),
        .skid_valid (skid_valid)
    );

    // Decode works on what ID actually sees, so an empty stage decodes the bubble.
    assign held_instr = main_valid ? main_instr : NOP_INSTR;
    assign fields     = mips_decode(held_instr);

    assign bus.out_valid       = main_valid;
    assign bus.IF_ID_Instr     = held_instr;
    assign bus.IF_ID_Opcode    = fields.opcode;
    assign bus.IF_ID_Rs        = fields.rs;
    assign bus.IF_ID_Rt        = fields.rt;
    assign bus.IF_ID_Rd        = fields.rd;
    assign bus.IF_ID_Shamt     = fields.shamt;
    assign bus.IF_ID_Func      = fields.func;
    assign bus.IF_ID_Immediate = fields.imm;
    assign bus.IF_ID_Address   = fields.jaddr;
    assign bus.IF_ID_PCplus4   = main_valid ? main_pc : '0;
    assign bus.stall_cnt       = stall_q;

    // Flush intentionally leaves the counter alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (main_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameters (name, default, meaning): INSTR_W, 32, instruction width in bits; fixed at 32 for MIPS field decode.
REQ-002 ADDR_W, 32, PC+4 width in bits.
REQ-003 CNT_W, 16, stall-counter width in bits.
REQ-004 NOP_INSTR, 32'h0000_0000, instruction value presented while the stage holds a bubble.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-006 Ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  squash all held and incoming instructions.
- in_valid  in  1  IF offers an instruction.
- in_ready  out  1  stage can accept an instruction.
- instruction  in  INSTR_W  fetched word.
- PCplus4  in  ADDR_W  fetch PC+4.
- out_valid  out  1  ID holds a valid instruction.
- out_ready  in  1  ID consumes the instruction.
- IF_ID_Instr  out  INSTR_W  held word, or NOP_INSTR when invalid.
- IF_ID_Opcode  out  6  instruction bits [31:26].
- IF_ID_Rs  out  5  instruction bits [25:21].
- IF_ID_Rt  out  5  instruction bits [20:16].
- IF_ID_Rd  out  5  instruction bits [15:11].
- IF_ID_Shamt  out  5  instruction bits [10:6].
- IF_ID_Func  out  6  instruction bits [5:0].
- IF_ID_Immediate  out  16  instruction bits [15:0].
- IF_ID_Address  out  26  instruction bits [25:0].
- IF_ID_PCplus4  out  ADDR_W  held PC+4; zero when invalid.
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles.

Function
REQ-007 Storage: two entries, main (drives outputs) and skid; each entry holds {valid, instruction, PCplus4}.
REQ-008 in_ready = !skid_valid; it is a registered value with no combinational path from out_ready.
REQ-009 Accept occurs when in_valid && in_ready; drain occurs when out_valid && out_ready; out_valid = main_valid.
REQ-010 Accept with main empty, or with main draining in the same cycle: the word loads into main; it appears on the outputs 1 cycle after accept.
REQ-011 Accept while main is valid and not draining: the word loads into skid, and in_ready deasserts next cycle.
REQ-012 Drain with skid valid: skid moves to main and skid_valid clears; any input accepted in that cycle loads into skid. No word is lost or duplicated.
REQ-013 Drain with skid empty and no accept: main_valid clears.
REQ-014 Ordering is strict FIFO; at most 2 words are in flight.
REQ-015 flush=1: main_valid and skid_valid clear at the next edge, and any word offered in that cycle is dropped; in_ready=1 in the following cycle.
REQ-016 Priority: reset > flush > accept/drain.
REQ-017 When out_valid=0: IF_ID_Instr=NOP_INSTR, all decoded fields are derived from NOP_INSTR, and IF_ID_PCplus4=0.
REQ-018 Decoded fields are combinational slices of the main entry; they add no extra latency.
REQ-019 stall_cnt increments by 1 on every cycle with out_valid && !out_ready; it saturates at 2^CNT_W-1 and does not wrap; flush does not clear it.

Reset
REQ-020 With rst_n=0 at a rising clk edge: main_valid=0, skid_valid=0, and stored data=0.
REQ-021 After reset: in_ready=1, out_valid=0, IF_ID_Instr=NOP_INSTR, IF_ID_PCplus4=0, stall_cnt=0.
REQ-022 Reset asserted mid-transfer discards both entries; no partial state survives.

Structure
REQ-023 Shared package mips_pipe_pkg: field bit-position constants, field widths, and the default NOP_INSTR value.
REQ-024 One sub-module, if_id_skid_buf, implements the 2-entry handshake storage; field decode and stall_cnt remain in if_id_stage.

Verification
REQ-025 Reset, then out_ready=1 and offer 0x012A4020 / PC+4 0x00000004 -> next cycle out_valid=1, Opcode=0, Rs=9, Rt=10, Rd=8, Func=0x20.
REQ-026 out_ready=0 and offer A then B -> in_ready=0 after B, stall_cnt counts; raise out_ready -> A, then B, one per cycle.
REQ-027 Two entries held, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, IF_ID_Instr=0x00000000, in_ready=1; the offered word never appears.
REQ-028 CNT_W=2, out_ready=0 for 6 cycles with out_valid=1 -> stall_cnt reaches 3 and holds at 3.
REQ-029 Continuous in_valid=1/out_ready=1 stream of 8 words -> 8 outputs in order at 1 per cycle, and in_ready stays 1 throughout.
REQ-030 rst_n=0 while two entries are held -> all outputs return to the REQ-021 values at the next edge.
